csa_reduce_pipe: RTL

CSA_REDUCE_PIPE -- requirements
Module: csa_reduce_pipe

---
 rtl/csa_reduce_pipe.sv | 124 ++++++++++++
 1 files changed

// File: rtl/csa_reduce_pipe.sv
// Pipelined carry-save reduction of NUM_OPS unsigned operands.
// Each reduction level runs one rank of 3:2 full-adder cells and is registered.
// A final stage registers the sum/carry pair plus their carry-propagate total.
// All arithmetic wraps mod 2^WIDTH.
//
// Handshake: a transaction moves on an edge where valid & ready are both high.
// Every stage, valid bits included, advances together when advance = out_ready | ~out_valid.
// in_ready equals advance. out_* hold steady while out_valid=1 and out_ready=0.
module csa_reduce_pipe #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic [WIDTH-1:0]         out_carry,
    output logic [WIDTH-1:0]         out_result
);

    // Number of vectors still alive at the input of reduction level lvl.
    function automatic int ops_at(input int lvl);
        int n;
        n = NUM_OPS;
        for (int i = 0; i < 8; i++) begin
            if (i < lvl) n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    // A level exists wherever more than two vectors remain.
    function automatic int num_levels();
        int l;
        l = 0;
        for (int i = 0; i < 8; i++) begin
            if (ops_at(i) > 2) l = i + 1;
        end
        return l;
    endfunction

    // Keeps indices in range on unrolled paths that are never taken.
    function automatic int clamp_idx(input int x);
        return (x > NUM_OPS - 1) ? NUM_OPS - 1 : x;
    endfunction

    function automatic int prev_idx(input int lvl);
        return (lvl == 0) ? 0 : lvl - 1;
    endfunction

    localparam int LEVELS = num_levels();

    logic                 advance;
    logic [WIDTH-1:0]     stage_d [LEVELS][NUM_OPS];
    logic [WIDTH-1:0]     stage_q [LEVELS][NUM_OPS];
    logic [LEVELS-1:0]    stage_v;
    logic [WIDTH-1:0]     src [NUM_OPS];
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     c;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Next contents of each level register.
    // Operand groups {3j,3j+1,3j+2} collapse to sum at slot 2j and carry at slot 2j+1.
    // Leftover operands move down unchanged behind the new vectors.
    always_comb begin
        a = '0;
        b = '0;
        c = '0;
        for (int k = 0; k < NUM_OPS; k++) src[k] = '0;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                src[k] = (lvl == 0) ? in_ops[k*WIDTH +: WIDTH] : stage_q[prev_idx(lvl)][k];
                stage_d[lvl][k] = '0;
            end
            for (int j = 0; j < NUM_OPS / 3; j++) begin
                if (j < ops_at(lvl) / 3) begin
                    a = src[3*j];
                    b = src[3*j+1];
                    c = src[3*j+2];
                    stage_d[lvl][2*j]   = a ^ b ^ c;
                    // Carry weight is one bit higher; the bit leaving the top is dropped.
                    stage_d[lvl][2*j+1] = ((a & b) | (a & c) | (b & c)) << 1;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (r < ops_at(lvl) % 3) begin
                    stage_d[lvl][clamp_idx(2 * (ops_at(lvl) / 3) + r)] =
                        src[clamp_idx(3 * (ops_at(lvl) / 3) + r)];
                end
            end
        end
    end

    // Level data registers.
    // Data in bubble stages is don't-care, so these have no reset.
    always_ff @(posedge clk) begin
        if (advance) stage_q <= stage_d;
    end

    // Valid pipeline and final output stage, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_v    <= '0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_carry  <= '0;
            out_result <= '0;
        end else if (advance) begin
            stage_v[0] <= in_valid;
            for (int l = 1; l < LEVELS; l++) stage_v[l] <= stage_v[l-1];
            out_valid  <= stage_v[LEVELS-1];
            out_sum    <= stage_q[LEVELS-1][0];
            out_carry  <= stage_q[LEVELS-1][1];
            out_result <= stage_q[LEVELS-1][0] + stage_q[LEVELS-1][1];
        end
    end

endmodule
